// File: rtl/smbus_filter_pkg.sv
// smbus_filter_pkg: shared defaults and timeout state type for the SMBus input filter
package smbus_filter_pkg;
  localparam int SMBUS_SYNC_STAGES_DEF    = 2;
  localparam int SMBUS_FILTER_CYCLES_DEF  = 4;
  localparam int SMBUS_IDLE_CYCLES_DEF    = 250;
  localparam int SMBUS_TIMEOUT_CYCLES_DEF = 1750000;
  typedef enum logic {TO_RUN, TO_HIT} smbus_to_state_t;
endpackage

// File: rtl/smbus_glitch_filter.sv
// smbus_glitch_filter: synchronizer plus stable-count deglitcher for one open-drain line
module smbus_glitch_filter
  import smbus_filter_pkg::*;
#(
  parameter int SYNC_STAGES   = SMBUS_SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = SMBUS_FILTER_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic filt_o
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic filt_q, filt_d, synced, hit;
  assign synced = sync_q[SYNC_STAGES-1];
  always_comb begin
    hit    = (synced != filt_q) && (cnt_q == CW'(FILTER_CYCLES - 1));
    cnt_d  = (synced == filt_q || hit) ? '0 : cnt_q + 1'b1;
    filt_d = hit ? synced : filt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end
  assign filt_o = filt_q;
endmodule

// File: rtl/smbus_input_filter.sv
// smbus_input_filter: deglitched SCL/SDA with START/STOP, idle and SCL-low timeout detection
// Optional SCL-low timeout FSM built only when SMBUS_TIMEOUT_EN is defined.
module smbus_input_filter
  import smbus_filter_pkg::*;
#(
  parameter int SYNC_STAGES    = SMBUS_SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES  = SMBUS_FILTER_CYCLES_DEF,
  parameter int IDLE_CYCLES    = SMBUS_IDLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = SMBUS_TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic i_reset,
  input  logic ia_scl_in,
  input  logic ia_sda_in,
  output logic o_scl_filt,
  output logic o_sda_filt,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_bus_idle,
  output logic o_scl_low_timeout
);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  logic scl_q, sda_q, start_q, stop_q, start_d, stop_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  smbus_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_scl (
    .clk(clk), .rst(i_reset), .line_i(ia_scl_in), .filt_o(o_scl_filt)
  );
  smbus_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_sda (
    .clk(clk), .rst(i_reset), .line_i(ia_sda_in), .filt_o(o_sda_filt)
  );
  // requiring SCL high in both cycles also rejects same-clock SCL/SDA changes
  always_comb begin
    start_d    = scl_q & o_scl_filt & sda_q & ~o_sda_filt;
    stop_d     = scl_q & o_scl_filt & ~sda_q & o_sda_filt;
    idle_cnt_d = (!o_scl_filt || !o_sda_filt || start_q) ? '0 :
                 (idle_cnt_q == IW'(IDLE_CYCLES)) ? idle_cnt_q : idle_cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      scl_q      <= o_scl_filt;
      sda_q      <= o_sda_filt;
      start_q    <= start_d;
      stop_q     <= stop_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end
  assign o_start_det = start_q;
  assign o_stop_det  = stop_q;
  assign o_bus_idle  = (idle_cnt_q == IW'(IDLE_CYCLES));
`ifdef SMBUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  smbus_to_state_t to_state_q, to_state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  always_comb begin
    to_state_d = to_state_q;
    to_cnt_d   = to_cnt_q;
    if (o_scl_filt) begin
      to_state_d = TO_RUN;
      to_cnt_d   = '0;
    end else if (to_state_q == TO_RUN) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES)) to_state_d = TO_HIT;
      else to_cnt_d = to_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      to_state_q <= TO_RUN;
      to_cnt_q   <= '0;
    end else begin
      to_state_q <= to_state_d;
      to_cnt_q   <= to_cnt_d;
    end
  end
  assign o_scl_low_timeout = (to_state_q == TO_HIT);
`else
  assign o_scl_low_timeout = 1'b0;
`endif
endmodule

// File: doc/smbus_input_filter.md
Name: smbus_input_filter

Overview:
- Front-end conditioning stage for one SMBus slave port. It sits directly upstream of the SMBus mailbox SDA/SCL inputs.
- Synchronizes the raw SCL and SDA pins and suppresses glitches with a stable-count filter.
- Detects START and STOP conditions, bus idle, and the SMBus SCL-low timeout.
- Filtered SCL/SDA drive the mailbox slave inputs. Status pulses and levels go to the Nios/recovery logic.
- Instantiated once per port: BMC and PCH.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per line; legal range 2..4.
- FILTER_CYCLES, 4, consecutive clocks a synced level must differ from the filtered output before the output flips; legal range 1..255.
- IDLE_CYCLES, 250, clocks with both filtered lines high before o_bus_idle asserts.
- TIMEOUT_CYCLES, 1750000, clocks of continuous filtered SCL low before o_scl_low_timeout asserts (35 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- i_reset  in  1  asynchronous active-high reset
- ia_scl_in  in  1  raw SCL pin, asynchronous
- ia_sda_in  in  1  raw SDA pin, asynchronous
- o_scl_filt  out  1  synchronized, deglitched SCL
- o_sda_filt  out  1  synchronized, deglitched SDA
- o_start_det  out  1  one-clock pulse on START or repeated START
- o_stop_det  out  1  one-clock pulse on STOP
- o_bus_idle  out  1  level; bus idle
- o_scl_low_timeout  out  1  level; SCL held low beyond TIMEOUT_CYCLES

Behaviour:
- Reset: the one clock is clk; i_reset is asynchronous and active-high. All registers clear asynchronously.
  - Synchronizer flops, o_scl_filt and o_sda_filt reset to 1 (released bus).
  - o_start_det, o_stop_det, o_bus_idle and o_scl_low_timeout reset to 0.
  - Deassertion is synchronous to clk. A reset mid-transfer abandons all state; no pulse is generated on reset exit.
- Synchronizer: SYNC_STAGES-flop chain per line, all flops reset to 1.
- Glitch filter (per line, identical):
  - Counter cnt, width $clog2(FILTER_CYCLES+1).
  - If synced equals filtered output: cnt <= 0.
  - Otherwise cnt increments. When cnt reaches FILTER_CYCLES-1 in a cycle where the inputs still differ, the output flips next clock and cnt <= 0.
  - Any pulse shorter than FILTER_CYCLES clocks is fully suppressed.
  - Latency from pin edge to filtered edge: SYNC_STAGES+FILTER_CYCLES clocks, ±1 for sampling.
- Edge detect: previous filtered values are held in scl_q and sda_q.
  - START: sda_q=1, o_sda_filt=0, scl_q=1, o_scl_filt=1.
  - STOP: sda_q=0, o_sda_filt=1, with SCL high in both cycles.
  - Each pulse is registered: it appears 1 clock after the filtered edge and lasts exactly 1 clock.
  - If SCL and SDA filtered outputs change in the same clock, neither START nor STOP is reported.
  - A repeated START is reported as an ordinary START.
- Bus idle: counter idle_cnt, width $clog2(IDLE_CYCLES+1).
  - Increments while both filtered lines are 1 and saturates at IDLE_CYCLES.
  - Clears when either line is 0.
  - o_bus_idle=1 exactly while idle_cnt==IDLE_CYCLES, so it is registered and asserts IDLE_CYCLES clocks after both lines go high.
  - Deasserts the clock after any line drops. o_start_det also forces idle_cnt to 0.
- SCL-low timeout, two-state FSM:
  - TO_RUN: counter to_cnt, width $clog2(TIMEOUT_CYCLES+1), increments while o_scl_filt=0 and clears when it is 1. When to_cnt reaches TIMEOUT_CYCLES, move to TO_HIT and assert o_scl_low_timeout.
  - TO_HIT: o_scl_low_timeout held at 1 regardless of SDA. Return to TO_RUN, clear the flag and clear to_cnt on the first clock with o_scl_filt=1.
  - to_cnt saturates and does not wrap.
- Filtered outputs are always passed through unmodified; the consumer decides how to react to timeout.

Optional Feature:
- Macro: SMBUS_TIMEOUT_EN.
- Defined: the timeout FSM and counter are built as described above.
- Undefined: no timeout counter or FSM is synthesized. o_scl_low_timeout is tied to 0 and TIMEOUT_CYCLES is ignored. All other behaviour is unchanged.

Decomposition:
- Package smbus_filter_pkg holds:
  - default constants SMBUS_SYNC_STAGES_DEF, SMBUS_FILTER_CYCLES_DEF, SMBUS_IDLE_CYCLES_DEF, SMBUS_TIMEOUT_CYCLES_DEF;
  - timeout state enum typedef smbus_to_state_t {TO_RUN, TO_HIT}.
- Sub-module smbus_glitch_filter contains the synchronizer plus stable-count filter for one line. It is instantiated twice, for SCL and SDA. Edge detect, idle and timeout logic stay in the top module.

Test Plan:
- Reset defaults: assert i_reset mid-simulation with pins driven 0 → o_scl_filt=o_sda_filt=1 immediately (asynchronous), all status outputs 0. Release reset with pins 1 → no start/stop pulse; o_bus_idle rises 250 clocks later.
- Glitch rejection (FILTER_CYCLES=4): 3-clock low pulse on ia_sda_in with SCL high → o_sda_filt stays 1, no o_start_det. Repeat with a 4-clock pulse → o_sda_filt falls, one o_start_det pulse, then o_stop_det on recovery.
- Latency: SDA falls with SCL high and pins otherwise stable → o_sda_filt falls 6 clocks after the pin edge (±1), o_start_det 1 clock later; o_bus_idle deasserts.
- Simultaneous edge: force SCL and SDA filtered transitions in the same clock (drive both pins in the same cycle) → neither o_start_det nor o_stop_det pulses.
- Full byte transfer: START, address 0x55 write, ACK clocked by the bench, STOP at 100 kHz → exactly one start pulse and one stop pulse, filtered waveform identical to the pin waveform delayed; the mailbox slave downstream ACKs.
- Timeout (SMBUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=1000): hold SCL low for 1010 clocks → o_scl_low_timeout rises at ~1000+latency and stays high. Release SCL → flag clears the clock after o_scl_filt=1. With the macro undefined the flag stays 0 throughout.
